regpair_seq: RTL and testbench
==============================

# regpair_seq

Sequencer that performs 16-bit register-pair operations (load, increment, decrement, copy) on the CPU's 8-bit register file. It turns one command into two consecutive single-byte read/write cycles. The block sits between the CPU control unit and the register file's single write port and combinational read port. It owns the carry between bytes and forces F's low nibble to zero when writing AF.

## Interface
Parameters:
- F_MASK, 8'hF0, AND-mask applied to every write to F (address 7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when a command can be accepted; equals (state==IDLE).
- cmd_op  input  2  0=LD16, 1=INC16, 2=DEC16, 3=CPY16.
- cmd_dst  input  2  destination pair: 0=BC, 1=DE, 2=HL, 3=AF.
- cmd_src  input  2  source pair (CPY16 only; ignored otherwise).
- cmd_imm  input  16  immediate value for LD16; high byte in [15:8].
- rf_raddr  output  3  register-file read address; file addresses are B0 C1 D2 E3 H4 L5 A6 F7.
- rf_rdata  input  8  combinational read data for rf_raddr.
- rf_waddr  output  3  register-file write address.
- rf_wdata  output  8  register-file write data.
- rf_we  output  1  register-file write enable; the write takes effect on the next clk edge.
- done  output  1  one-cycle pulse when the command is complete.
- result  output  16  final 16-bit value written to the destination pair; valid while done is high, held until the next done.

## Operation
- Pair mapping: high byte at address 2p, low byte at address 2p+1.
- States:
  - IDLE → LO on accept.
  - LO → HI.
  - HI → IDLE.
- Accept: cmd_valid & cmd_ready at a clk edge. op, dst, src and imm are latched at that edge. Inputs are ignored at all other times.
- LO cycle: rf_we=1, rf_waddr=2·dst+1.
  - rf_raddr=2·src+1 for CPY16; otherwise 2·dst+1.
  - Write data by op:
    - LD16: imm[7:0].
    - INC16: rdata+1; c = (rdata==FF).
    - DEC16: rdata−1; c = (rdata==00).
    - CPY16: rdata.
  - The carry/borrow flag c is registered at the end of LO.
- HI cycle: rf_we=1, rf_waddr=2·dst.
  - rf_raddr=2·src for CPY16; otherwise 2·dst.
  - Write data by op:
    - LD16: imm[15:8].
    - INC16: rdata+c.
    - DEC16: rdata−c.
    - CPY16: rdata.
- F_MASK is applied to rf_wdata whenever rf_waddr==7. result reflects the masked value.
- Arithmetic is mod 2^16: FFFF+1=0000 and 0000−1=FFFF. There is no flag output.
- Exactly two writes per command, always, even when the high byte is unchanged.
- CPY16 with src==dst rewrites identical values, except that F is masked.
- In IDLE: rf_we=0 and rf_raddr=rf_waddr=0.

## Timing
- Accept at edge N:
  - LO is cycle N→N+1.
  - HI is cycle N+1→N+2.
  - done=1 and result are valid in cycle N+2→N+3.
- cmd_ready is high in that same done cycle, so back-to-back commands issue every 3 cycles.
- done is registered and asserted in the IDLE cycle following HI. It is deasserted after one cycle unless it re-asserts after the next HI.
- Reads are same-cycle combinational. A write in LO is visible to reads in HI. The write-after-read in the same cycle returns the old value.
- Reset values: state=IDLE, cmd_ready=1, rf_we=0, done=0, result=0000, c=0, latched command=0.
- Reset asserted mid-command:
  - Immediately forces IDLE and rf_we=0.
  - No further writes occur; a low byte already written stays written.
  - No done is produced.
- cmd_valid held high across busy cycles causes no action until IDLE.

## Test plan
- Reset: assert rst asynchronously mid-HI → rf_we drops without waiting for clk. After release: cmd_ready=1, done=0, result=0000.
- LD16 HL=1234 → write 34 to addr 5 at N+1, write 12 to addr 4 at N+2. done at N+2→N+3 with result=1234.
- INC16 on DE=12FF, then INC16 on DE=FFFF → results 1300 and 0000 (wrap). Each command issues exactly two writes.
- DEC16 on BC=0100, then DEC16 on BC=0000 → results 00FF and FFFF.
- CPY16 BC→AF with BC=ABCD → A=AB, F=C0, result=ABC0. Also LD16 AF=12FF → F=F0.
- Back-to-back: cmd_valid held with INC16 HL=0000 three times → done pulses 3 cycles apart with results 0001, 0002, 0003. No accept occurs while cmd_ready=0.

Source files
------------

// File: rtl/regpair_seq_if.sv
// Command and register-file port bundle for regpair_seq.
// The slave modport is the sequencer's view; master is the control unit / register file side.
interface regpair_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_dst;
    logic [1:0]  cmd_src;
    logic [15:0] cmd_imm;
    logic [2:0]  rf_raddr;
    logic [7:0]  rf_rdata;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        rf_we;
    logic        done;
    logic [15:0] result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_rdata,
        output cmd_ready, rf_raddr, rf_waddr, rf_wdata, rf_we, done, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_rdata,
        input  cmd_ready, rf_raddr, rf_waddr, rf_wdata, rf_we, done, result
    );
endinterface

// File: rtl/regpair_seq.sv
// Turns one 16-bit register-pair command into a low-byte then high-byte
// read/modify/write on the 8-bit register file, carrying between the bytes.
module regpair_seq #(
    parameter logic [7:0] F_MASK = 8'hF0
) (
    input  logic         clk,
    input  logic         rst,
    regpair_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    typedef enum logic [1:0] {OP_LD, OP_INC, OP_DEC, OP_CPY} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [1:0]  dst_q, dst_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] imm_q, imm_d;
    logic        c_q, c_d;
    logic [7:0]  lo_q, lo_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;

    logic [2:0]  raddr;
    logic [2:0]  waddr;
    logic [7:0]  wdata_raw;
    logic [7:0]  wdata;
    logic        we;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src_d     = src_q;
        imm_d     = imm_q;
        c_d       = c_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        result_d  = result_q;
        raddr     = 3'd0;
        waddr     = 3'd0;
        wdata_raw = 8'd0;
        we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = op_t'(bus.cmd_op);
                    dst_d   = bus.cmd_dst;
                    src_d   = bus.cmd_src;
                    imm_d   = bus.cmd_imm;
                    state_d = LO;
                end
            end
            LO: begin
                we    = 1'b1;
                waddr = {dst_q, 1'b1};
                raddr = (op_q == OP_CPY) ? {src_q, 1'b1} : {dst_q, 1'b1};
                case (op_q)
                    OP_LD:  wdata_raw = imm_q[7:0];
                    OP_INC: begin
                        wdata_raw = bus.rf_rdata + 8'd1;
                        c_d       = (bus.rf_rdata == 8'hFF);
                    end
                    OP_DEC: begin
                        wdata_raw = bus.rf_rdata - 8'd1;
                        c_d       = (bus.rf_rdata == 8'h00);
                    end
                    default: wdata_raw = bus.rf_rdata;
                endcase
                state_d = HI;
            end
            HI: begin
                we    = 1'b1;
                waddr = {dst_q, 1'b0};
                raddr = (op_q == OP_CPY) ? {src_q, 1'b0} : {dst_q, 1'b0};
                case (op_q)
                    OP_LD:   wdata_raw = imm_q[15:8];
                    OP_INC:  wdata_raw = bus.rf_rdata + {7'd0, c_q};
                    OP_DEC:  wdata_raw = bus.rf_rdata - {7'd0, c_q};
                    default: wdata_raw = bus.rf_rdata;
                endcase
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // F only ever holds flag bits, so its low nibble is cleared on every write
        wdata = (waddr == 3'd7) ? (wdata_raw & F_MASK) : wdata_raw;

        if (state_q == LO) begin
            lo_d = wdata;
        end
        if (state_q == HI) begin
            result_d = {wdata, lo_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LD;
            dst_q    <= 2'd0;
            src_q    <= 2'd0;
            imm_q    <= 16'd0;
            c_q      <= 1'b0;
            lo_q     <= 8'd0;
            done_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            imm_q    <= imm_d;
            c_q      <= c_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rf_raddr  = raddr;
    assign bus.rf_waddr  = waddr;
    assign bus.rf_wdata  = wdata;
    assign bus.rf_we     = we;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_regpair_seq.sv
// Randomized and directed bench for regpair_seq against a pair-level model of
// the register file; a per-cycle comparator checks every output.
module tb_regpair_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    regpair_seq_if ifc ();

    regpair_seq #(.F_MASK(8'hF0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] rf_mem [8];
    logic [7:0] model_mem [8];

    assign ifc.rf_rdata = rf_mem[ifc.rf_raddr];

    always @(posedge clk) begin
        if (ifc.rf_we) rf_mem[ifc.rf_waddr] <= ifc.rf_wdata;
    end

    typedef struct {
        bit          we;
        logic [2:0]  raddr;
        logic [2:0]  waddr;
        logic [7:0]  wdata;
        bit          done;
        logic [15:0] result;
        bit          ready;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] last_result = 16'd0;
    bit          cmp_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] modelPair(input logic [1:0] p);
        return {model_mem[{p, 1'b0}], model_mem[{p, 1'b1}]};
    endfunction

    // Model: on each accepted command compute the final pair value from the
    // arithmetic rules, then queue the three cycles the outputs must show.
    always @(posedge clk) begin
        if (cmp_en && !rst && ifc.cmd_valid && exp_q.size() == 0) begin
            logic [15:0] v;
            exp_t        e;
            bit          cpy;
            cpy = (ifc.cmd_op == 2'd3);
            case (ifc.cmd_op)
                2'd0:    v = ifc.cmd_imm;
                2'd1:    v = modelPair(ifc.cmd_dst) + 16'd1;
                2'd2:    v = modelPair(ifc.cmd_dst) - 16'd1;
                default: v = modelPair(ifc.cmd_src);
            endcase
            if (ifc.cmd_dst == 2'd3) v[7:0] = v[7:0] & 8'hF0;
            model_mem[{ifc.cmd_dst, 1'b0}] = v[15:8];
            model_mem[{ifc.cmd_dst, 1'b1}] = v[7:0];

            e = '{we: 1'b1, raddr: cpy ? {ifc.cmd_src, 1'b1} : {ifc.cmd_dst, 1'b1},
                  waddr: {ifc.cmd_dst, 1'b1}, wdata: v[7:0], done: 1'b0, result: 16'd0, ready: 1'b0};
            exp_q.push_back(e);
            e = '{we: 1'b1, raddr: cpy ? {ifc.cmd_src, 1'b0} : {ifc.cmd_dst, 1'b0},
                  waddr: {ifc.cmd_dst, 1'b0}, wdata: v[15:8], done: 1'b0, result: 16'd0, ready: 1'b0};
            exp_q.push_back(e);
            e = '{we: 1'b0, raddr: 3'd0, waddr: 3'd0, wdata: 8'd0, done: 1'b1, result: v, ready: 1'b1};
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{we: 1'b0, raddr: 3'd0, waddr: 3'd0, wdata: 8'd0, done: 1'b0, result: 16'd0, ready: 1'b1};
            if (e.done) last_result = e.result;
            checkOutput("cyc_rf_we", 16'(ifc.rf_we), 16'(e.we));
            checkOutput("cyc_ready", 16'(ifc.cmd_ready), 16'(e.ready));
            checkOutput("cyc_done", 16'(ifc.done), 16'(e.done));
            checkOutput("cyc_raddr", 16'(ifc.rf_raddr), 16'(e.raddr));
            checkOutput("cyc_waddr", 16'(ifc.rf_waddr), 16'(e.waddr));
            if (e.we) checkOutput("cyc_wdata", 16'(ifc.rf_wdata), 16'(e.wdata));
            checkOutput("cyc_result", ifc.result, last_result);
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                                 input logic [15:0] imm, output logic [15:0] res, output int nwr);
        int w;
        bit got;
        nwr = 0;
        res = 16'hxxxx;
        w   = 0;
        @(negedge clk);
        while (!ifc.cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ready_wait", 16'(ifc.cmd_ready), 16'd1);
        ifc.cmd_op    = op;
        ifc.cmd_dst   = dst;
        ifc.cmd_src   = src;
        ifc.cmd_imm   = imm;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ifc.rf_we) nwr++;
            if (ifc.done) begin
                res = ifc.result;
                got = 1'b1;
            end else if (!ifc.cmd_ready) begin
                // busy: scramble inputs, they must have no effect
                ifc.cmd_valid = 1'($urandom_range(0, 1));
                ifc.cmd_op    = 2'($urandom_range(0, 3));
                ifc.cmd_dst   = 2'($urandom_range(0, 3));
                ifc.cmd_src   = 2'($urandom_range(0, 3));
                ifc.cmd_imm   = 16'($urandom);
            end
        end
        ifc.cmd_valid = 1'b0;
        checkOutput("done_seen", 16'(got), 16'd1);
    endtask

    task automatic runCmd(input string name, input logic [1:0] op, input logic [1:0] dst,
                          input logic [1:0] src, input logic [15:0] imm, input logic [15:0] want);
        logic [15:0] res;
        int          nwr;
        applyStimulus(op, dst, src, imm, res, nwr);
        checkOutput(name, res, want);
        checkOutput({name, "_writes"}, 16'(nwr), 16'd2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  old_h;
        logic [15:0] res;
        int          nwr;
        int          accepts;
        int          ndone;
        int          done_cyc [3];
        logic [15:0] done_res [3];

        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'd0;
        ifc.cmd_dst   = 2'd0;
        ifc.cmd_src   = 2'd0;
        ifc.cmd_imm   = 16'd0;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i]    = 8'($urandom);
            model_mem[i] = rf_mem[i];
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_ready", 16'(ifc.cmd_ready), 16'd1);
        checkOutput("reset_we", 16'(ifc.rf_we), 16'd0);
        checkOutput("reset_done", 16'(ifc.done), 16'd0);
        checkOutput("reset_result", ifc.result, 16'h0000);
        checkOutput("reset_raddr", 16'(ifc.rf_raddr), 16'd0);
        cmp_en = 1'b1;

        $display("[TB] directed commands");
        runCmd("ld_hl", 2'd0, 2'd2, 2'd0, 16'h1234, 16'h1234);
        checkOutput("ld_hl_h", 16'(rf_mem[4]), 16'h0012);
        checkOutput("ld_hl_l", 16'(rf_mem[5]), 16'h0034);
        runCmd("ld_de", 2'd0, 2'd1, 2'd0, 16'h12FF, 16'h12FF);
        runCmd("inc_de_carry", 2'd1, 2'd1, 2'd0, 16'h0000, 16'h1300);
        runCmd("ld_de2", 2'd0, 2'd1, 2'd0, 16'hFFFF, 16'hFFFF);
        runCmd("inc_de_wrap", 2'd1, 2'd1, 2'd0, 16'h0000, 16'h0000);
        runCmd("ld_bc", 2'd0, 2'd0, 2'd0, 16'h0100, 16'h0100);
        runCmd("dec_bc_borrow", 2'd2, 2'd0, 2'd0, 16'h0000, 16'h00FF);
        runCmd("ld_bc2", 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000);
        runCmd("dec_bc_wrap", 2'd2, 2'd0, 2'd0, 16'h0000, 16'hFFFF);
        runCmd("ld_bc3", 2'd0, 2'd0, 2'd0, 16'hABCD, 16'hABCD);
        runCmd("cpy_bc_af", 2'd3, 2'd3, 2'd0, 16'h0000, 16'hABC0);
        checkOutput("cpy_a", 16'(rf_mem[6]), 16'h00AB);
        checkOutput("cpy_f", 16'(rf_mem[7]), 16'h00C0);
        runCmd("ld_af_mask", 2'd0, 2'd3, 2'd0, 16'h12FF, 16'h12F0);
        checkOutput("ld_af_f", 16'(rf_mem[7]), 16'h00F0);

        $display("[TB] reset during HI");
        cmp_en = 1'b0;
        @(negedge clk);
        old_h = model_mem[4];
        ifc.cmd_op    = 2'd0;
        ifc.cmd_dst   = 2'd2;
        ifc.cmd_imm   = 16'h5A3C;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("hi_we_before_rst", 16'(ifc.rf_we), 16'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_we", 16'(ifc.rf_we), 16'd0);
        checkOutput("rst_async_ready", 16'(ifc.cmd_ready), 16'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 16'(ifc.cmd_ready), 16'd1);
        checkOutput("rst_done", 16'(ifc.done), 16'd0);
        checkOutput("rst_result", ifc.result, 16'h0000);
        checkOutput("rst_lo_kept", 16'(rf_mem[5]), 16'h003C);
        checkOutput("rst_hi_untouched", 16'(rf_mem[4]), 16'(old_h));
        model_mem[5] = 8'h3C;
        last_result  = 16'h0000;
        exp_q.delete();
        cmp_en = 1'b1;

        $display("[TB] back-to-back INC16 HL");
        runCmd("ld_hl_zero", 2'd0, 2'd2, 2'd0, 16'h0000, 16'h0000);
        ifc.cmd_op    = 2'd1;
        ifc.cmd_dst   = 2'd2;
        ifc.cmd_src   = 2'd0;
        ifc.cmd_valid = 1'b1;
        accepts = 0;
        ndone   = 0;
        for (int cyc = 0; cyc < 30 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (ifc.done) begin
                done_cyc[ndone] = cyc;
                done_res[ndone] = ifc.result;
                ndone++;
            end
            if (ifc.cmd_ready) begin
                if (accepts < 3) accepts++;
                else ifc.cmd_valid = 1'b0;
            end
        end
        ifc.cmd_valid = 1'b0;
        checkOutput("b2b_ndone", 16'(ndone), 16'd3);
        if (ndone == 3) begin
            checkOutput("b2b_res0", done_res[0], 16'h0001);
            checkOutput("b2b_res1", done_res[1], 16'h0002);
            checkOutput("b2b_res2", done_res[2], 16'h0003);
            checkOutput("b2b_gap1", 16'(done_cyc[1] - done_cyc[0]), 16'd3);
            checkOutput("b2b_gap2", 16'(done_cyc[2] - done_cyc[1]), 16'd3);
        end

        $display("[TB] random commands");
        for (int n = 0; n < 150; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          16'($urandom), res, nwr);
            checkOutput("rand_writes", 16'(nwr), 16'd2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            checkOutput("final_rf", 16'(rf_mem[i]), 16'(model_mem[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
